// File: rtl/serial_adder_pkg.sv
// Shared state encoding and sizing helpers for the bit-serial adder.
package serial_adder_pkg;

  localparam int unsigned SA_STW = 2;

  typedef enum logic [SA_STW-1:0] {
    SA_IDLE = 2'd0,
    SA_RUN  = 2'd1,
    SA_DONE = 2'd2
  } sa_state_t;

  // One spare bit keeps the counter meaningful when WIDTH is 1.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/serial_adder_cell.sv
// Combinational one-bit full adder driven by the serial adder each cycle.
module full_adder_cell (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic cout,
  output logic s
);

  assign s    = x ^ y ^ cin;
  assign cout = (x & y) | (cin & (x ^ y));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: operands shift LSB-first through one full-adder
// cell, the carry is held in a flop between bit-cycles.
import serial_adder_pkg::*;

module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CW = cnt_width(WIDTH);

  sa_state_t        state, state_n;
  logic [WIDTH-1:0] a_sh, b_sh, sum_sh, sum_sh_n;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             accept, last;
  logic             fa_s, fa_c;

  full_adder_cell u_fa (
    .x    (a_sh[0]),
    .y    (b_sh[0]),
    .cin  (carry),
    .cout (fa_c),
    .s    (fa_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= SA_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    last    = 1'b0;
    case (state)
      SA_IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_n = SA_RUN;
        end
      end
      SA_RUN: begin
        if (cnt == CW'(WIDTH - 1)) begin
          last    = 1'b1;
          state_n = SA_DONE;
        end
      end
      SA_DONE: state_n = SA_IDLE;
      default: state_n = SA_IDLE;
    endcase
  end

  // Shift-then-insert form stays legal when WIDTH is 1.
  always_comb begin
    sum_sh_n            = sum_sh >> 1;
    sum_sh_n[WIDTH-1]   = fa_s;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      busy <= (state_n == SA_RUN);
      done <= (state_n == SA_DONE);
      if (accept) begin
        a_sh   <= a;
        b_sh   <= b;
        carry  <= cin;
        cnt    <= '0;
        sum_sh <= '0;
      end else if (state == SA_RUN) begin
        a_sh   <= a_sh >> 1;
        b_sh   <= b_sh >> 1;
        sum_sh <= sum_sh_n;
        carry  <= fa_c;
        cnt    <= cnt + CW'(1);
      end
      if (last) begin
        sum  <= sum_sh_n;
        cout <= fa_c;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Randomized and directed bench for serial_adder (WIDTH=8 and WIDTH=1).
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       start8, start1;
  logic [7:0] a8, b8;
  logic       cin8;
  logic       busy8, done8, cout8;
  logic [7:0] sum8;
  logic [0:0] a1, b1, sum1;
  logic       cin1, busy1, done1, cout1;

  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One WIDTH=8 operation; hammer keeps start high (a=8'h11) while RUN/DONE.
  task automatic run8(input logic [7:0] av, input logic [7:0] bv, input logic cv, input bit hammer);
    logic [8:0] exp;
    exp = {1'b0, av} + {1'b0, bv} + {8'd0, cv};
    @(negedge clk);
    a8 = av; b8 = bv; cin8 = cv; start8 = 1'b1;
    @(posedge clk); #1;
    check("busy_after_accept", {31'd0, busy8}, 32'd1);
    check("done_after_accept", {31'd0, done8}, 32'd0);
    for (int i = 2; i <= 9; i++) begin
      @(negedge clk);
      start8 = hammer;
      a8 = hammer ? 8'h11 : 8'($urandom);
      b8 = 8'($urandom);
      cin8 = 1'($urandom);
      @(posedge clk); #1;
      if (i < 9) begin
        check("busy_run", {31'd0, busy8}, 32'd1);
        check("done_run", {31'd0, done8}, 32'd0);
      end else begin
        check("done_pulse", {31'd0, done8}, 32'd1);
        check("busy_at_done", {31'd0, busy8}, 32'd0);
        check("sum", {24'd0, sum8}, {24'd0, exp[7:0]});
        check("cout", {31'd0, cout8}, {31'd0, exp[8]});
      end
    end
    @(negedge clk);
    start8 = hammer;
    @(posedge clk); #1;
    check("done_single", {31'd0, done8}, 32'd0);
    check("busy_after_done", {31'd0, busy8}, 32'd0);
    check("sum_held", {24'd0, sum8}, {24'd0, exp[7:0]});
    check("cout_held", {31'd0, cout8}, {31'd0, exp[8]});
    @(negedge clk);
    start8 = 1'b0;
  endtask

  task automatic run8_now(input logic [7:0] av, input logic [7:0] bv, input logic cv);
    run8(av, bv, cv, 1'b0);
  endtask

  task automatic run1(input logic av, input logic bv, input logic cv);
    logic [1:0] exp;
    exp = {1'b0, av} + {1'b0, bv} + {1'b0, cv};
    @(negedge clk);
    a1 = av; b1 = bv; cin1 = cv; start1 = 1'b1;
    @(posedge clk); #1;
    check("w1_busy", {31'd0, busy1}, 32'd1);
    check("w1_done_early", {31'd0, done1}, 32'd0);
    @(negedge clk);
    start1 = 1'b0; a1 = ~av; b1 = ~bv; cin1 = ~cv;
    @(posedge clk); #1;
    check("w1_done", {31'd0, done1}, 32'd1);
    check("w1_sum", {31'd0, sum1}, {31'd0, exp[0]});
    check("w1_cout", {31'd0, cout1}, {31'd0, exp[1]});
    @(posedge clk); #1;
    check("w1_done_drop", {31'd0, done1}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; start8 = 1'b0; start1 = 1'b0;
    a8 = '0; b8 = '0; cin8 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    #1;
    check("rst_busy", {31'd0, busy8}, 32'd0);
    check("rst_done", {31'd0, done8}, 32'd0);
    check("rst_sum", {24'd0, sum8}, 32'd0);
    check("rst_cout", {31'd0, cout8}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;

    run8_now(8'h00, 8'h00, 1'b0);
    run8_now(8'hFF, 8'h01, 1'b0);
    run8_now(8'h5A, 8'hA5, 1'b1);
    run8_now(8'h3C, 8'h42, 1'b0);
    run8(8'h81, 8'h7F, 1'b1, 1'b1);

    // Reset at bit-cycle 4 of F0+0F; prior result (81+7F+1) is non-zero.
    @(negedge clk);
    a8 = 8'hF0; b8 = 8'h0F; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk); start8 = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", {31'd0, busy8}, 32'd0);
    check("abort_done", {31'd0, done8}, 32'd0);
    check("abort_sum", {24'd0, sum8}, 32'd0);
    check("abort_cout", {31'd0, cout8}, 32'd0);
    @(negedge clk); rst = 1'b0;
    run8_now(8'hF0, 8'h0F, 1'b1);

    for (int n = 0; n < 20; n++)
      run8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom_range(0, 1)));

    for (int v = 0; v < 8; v++) begin
      logic [2:0] t;
      t = 3'(v);
      run1(t[2], t[1], t[0]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
